// File: rtl/ebr_fifo_pkg.sv
// Shared constants and helpers for the EBR_B-backed FIFO controller.
package ebr_fifo_pkg;

    localparam int EBR_BITS = 4096;

    function automatic int addr_width_for(input int data_width);
        return $clog2(EBR_BITS / data_width);
    endfunction

    // EBR_B takes its port width as a string parameter.
    function automatic string ebr_width_str(input int data_width);
        case (data_width)
            16:      return "16";
            8:       return "8";
            4:       return "4";
            2:       return "2";
            default: return "16";
        endcase
    endfunction

endpackage

// File: rtl/ebr_fifo_ctrl_if.sv
// Producer/consumer valid-ready stream pair seen by the FIFO controller.
interface ebr_fifo_ctrl_if #(parameter int DATA_WIDTH = 16);

    logic [DATA_WIDTH-1:0] IN_DATA;
    logic                  IN_VALID;
    logic                  IN_READY;
    logic [DATA_WIDTH-1:0] OUT_DATA;
    logic                  OUT_VALID;
    logic                  OUT_READY;

    modport master (output IN_DATA, IN_VALID, OUT_READY,
                    input  IN_READY, OUT_DATA, OUT_VALID);

    modport slave  (input  IN_DATA, IN_VALID, OUT_READY,
                    output IN_READY, OUT_DATA, OUT_VALID);

endinterface

// File: rtl/ebr_fifo_skid.sv
// Two-entry FIFO register stage holding prefetched RAM words ahead of the consumer.
module ebr_fifo_skid
    import ebr_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            cnt
);

    logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]            cnt_q, cnt_d;

    // Next-state: fill lands in the first free slot; pop shifts tail into head.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_d = data;
                    end else begin
                        tail_d = data;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    head_d = tail_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_d = data;
                    end else begin
                        head_d = tail_q;
                        tail_d = data;
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= {DATA_WIDTH{1'b0}};
            tail_q <= {DATA_WIDTH{1'b0}};
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head = head_q;
    assign cnt  = cnt_q;

endmodule

// File: rtl/ebr_fifo_ctrl.sv
// Circular-buffer controller for one EBR_B RAM with a 2-entry first-word-fall-through skid stage.
module ebr_fifo_ctrl
    import ebr_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int AFULL_LEVEL  = 240,
    parameter int AEMPTY_LEVEL = 4
) (
    input  logic                  CK,
    input  logic                  RST_N,
    input  logic                  FLUSH,
    ebr_fifo_ctrl_if.slave        strm,
    output logic [ADDR_WIDTH+1:0] COUNT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic                  OVERFLOW,
    output logic [ADDR_WIDTH-1:0] RAM_WADDR,
    output logic [DATA_WIDTH-1:0] RAM_WDATA,
    output logic                  RAM_WE,
    output logic                  RAM_WCLKE,
    output logic [DATA_WIDTH-1:0] RAM_MASK_N,
    output logic [ADDR_WIDTH-1:0] RAM_RADDR,
    output logic                  RAM_RE,
    output logic                  RAM_RCLKE,
    input  logic [DATA_WIDTH-1:0] RAM_RDATA
);

    localparam int CW = ADDR_WIDTH + 2;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CW-1:0]       AFULL_C  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0]       AEMPTY_C = CW'(AEMPTY_LEVEL);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  afull_q, afull_d, aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;

    logic                  clr_s, push_s, pop_s, issue_s, out_valid_s;
    logic [1:0]            skid_cnt_s, skid_cnt_nx_s;
    logic [2:0]            skid_occ_s;
    logic [DATA_WIDTH-1:0] skid_head_s;

    // Handshakes; pushes and reads are suppressed while clearing so the RAM sees no enables.
    always_comb begin
        clr_s       = FLUSH | ~RST_N;
        out_valid_s = (skid_cnt_s != 2'd0);
        pop_s       = out_valid_s & strm.OUT_READY;
        push_s      = strm.IN_VALID & ~full_q & ~clr_s;
        skid_occ_s  = {1'b0, skid_cnt_s} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_s     = (ram_cnt_q != {(ADDR_WIDTH+1){1'b0}}) & (skid_occ_s < 3'd2) & ~clr_s;
    end

    // Pointer, occupancy and flag next-state; flags come from next-state totals.
    always_comb begin
        if (FLUSH) begin
            wptr_d        = {ADDR_WIDTH{1'b0}};
            rptr_d        = {ADDR_WIDTH{1'b0}};
            ram_cnt_d     = {(ADDR_WIDTH+1){1'b0}};
            inflight_d    = 1'b0;
            skid_cnt_nx_s = 2'd0;
            ovf_d         = 1'b0;
        end else begin
            wptr_d        = wptr_q + {{(ADDR_WIDTH-1){1'b0}}, push_s};
            rptr_d        = rptr_q + {{(ADDR_WIDTH-1){1'b0}}, issue_s};
            ram_cnt_d     = ram_cnt_q + {{ADDR_WIDTH{1'b0}}, push_s}
                                      - {{ADDR_WIDTH{1'b0}}, issue_s};
            inflight_d    = issue_s;
            skid_cnt_nx_s = skid_cnt_s + {1'b0, inflight_q} - {1'b0, pop_s};
            ovf_d         = ovf_q | (strm.IN_VALID & full_q);
        end
        count_d  = {1'b0, ram_cnt_d} + {{(CW-1){1'b0}}, inflight_d}
                                     + {{(CW-2){1'b0}}, skid_cnt_nx_s};
        full_d   = (ram_cnt_d == DEPTH_C);
        empty_d  = (count_d == {CW{1'b0}});
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);
    end

    // State registers with synchronous reset.
    always_ff @(posedge CK) begin
        if (!RST_N) begin
            wptr_q     <= {ADDR_WIDTH{1'b0}};
            rptr_q     <= {ADDR_WIDTH{1'b0}};
            ram_cnt_q  <= {(ADDR_WIDTH+1){1'b0}};
            count_q    <= {CW{1'b0}};
            inflight_q <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
            ovf_q      <= ovf_d;
        end
    end

    // A read in flight during FLUSH is dropped by gating the fill.
    ebr_fifo_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk   (CK),
        .rst_n (RST_N),
        .clr   (FLUSH),
        .push  (inflight_q & ~FLUSH),
        .data  (RAM_RDATA),
        .pop   (pop_s),
        .head  (skid_head_s),
        .cnt   (skid_cnt_s)
    );

    assign strm.IN_READY  = ~full_q;
    assign strm.OUT_VALID = out_valid_s;
    assign strm.OUT_DATA  = skid_head_s;

    assign COUNT        = count_q;
    assign FULL         = full_q;
    assign EMPTY        = empty_q;
    assign ALMOST_FULL  = afull_q;
    assign ALMOST_EMPTY = aempty_q;
    assign OVERFLOW     = ovf_q;

    assign RAM_WADDR  = wptr_q;
    assign RAM_WDATA  = strm.IN_DATA;
    assign RAM_WE     = push_s;
    assign RAM_WCLKE  = push_s;
    assign RAM_MASK_N = {DATA_WIDTH{1'b0}};
    assign RAM_RADDR  = rptr_q;
    assign RAM_RE     = issue_s;
    assign RAM_RCLKE  = issue_s;

endmodule

// File: tb/tb_ebr_fifo_ctrl.sv
// Directed bench for ebr_fifo_ctrl with a behavioural EBR model.
module tb_ebr_fifo_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush;
    logic [9:0]  count;
    logic        full, empty, afull, aempty, ovf;
    logic [7:0]  waddr, raddr;
    logic [15:0] wdata, mask_n;
    logic [15:0] rdata = 16'h0000;
    logic        we, wclke, re, rclke;
    logic [15:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    ebr_fifo_ctrl_if #(.DATA_WIDTH(16)) bus ();

    ebr_fifo_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .AFULL_LEVEL(240), .AEMPTY_LEVEL(4)) dut (
        .CK(clk), .RST_N(rst_n), .FLUSH(flush), .strm(bus),
        .COUNT(count), .FULL(full), .EMPTY(empty), .ALMOST_FULL(afull),
        .ALMOST_EMPTY(aempty), .OVERFLOW(ovf),
        .RAM_WADDR(waddr), .RAM_WDATA(wdata), .RAM_WE(we), .RAM_WCLKE(wclke),
        .RAM_MASK_N(mask_n), .RAM_RADDR(raddr), .RAM_RE(re), .RAM_RCLKE(rclke),
        .RAM_RDATA(rdata)
    );

    always @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pushed, n, bad, stall, sent, recv, waddr_bad, wrapped, gaps;
        logic [7:0] wp;
        logic did_push;

        rst_n = 1'b0; flush = 1'b0;
        bus.IN_VALID = 1'b1; bus.IN_DATA = 16'h1234; bus.OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_we", 32'(we), 32'h0);
        end
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_aempty", 32'(aempty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_out_valid", 32'(bus.OUT_VALID), 32'h0);
        check("rst_overflow", 32'(ovf), 32'h0);
        check("rst_re", 32'(re), 32'h0);
        check("mask_n", 32'(mask_n), 32'h0);
        rst_n = 1'b1; bus.IN_VALID = 1'b0;
        tick();

        // Latency: push at t, issue at t+1, skid at t+3.
        bus.IN_VALID = 1'b1; bus.IN_DATA = 16'hA5A5;
        #1;
        check("lat_we", 32'(we), 32'h1);
        check("lat_wclke", 32'(wclke), 32'h1);
        check("lat_waddr", 32'(waddr), 32'h0);
        tick();
        bus.IN_VALID = 1'b0;
        #1;
        check("lat_re", 32'(re), 32'h1);
        check("lat_raddr", 32'(raddr), 32'h0);
        check("lat_valid_t1", 32'(bus.OUT_VALID), 32'h0);
        check("lat_count_t1", 32'(count), 32'd1);
        tick();
        check("lat_valid_t2", 32'(bus.OUT_VALID), 32'h0);
        check("lat_count_t2", 32'(count), 32'd1);
        tick();
        check("lat_valid_t3", 32'(bus.OUT_VALID), 32'h1);
        check("lat_data_t3", 32'(bus.OUT_DATA), 32'hA5A5);
        check("lat_empty_t3", 32'(empty), 32'h0);
        tick();
        check("lat_empty_after", 32'(empty), 32'h1);
        check("lat_valid_after", 32'(bus.OUT_VALID), 32'h0);
        check("lat_count_after", 32'(count), 32'd0);

        // Fill with consumer stalled: 256 in RAM plus 2 in the skid stage.
        bus.OUT_READY = 1'b0; bus.IN_VALID = 1'b1; pushed = 0;
        while (pushed < 300) begin
            bus.IN_DATA = 16'h1000 + 16'(pushed);
            #1;
            if (!bus.IN_READY) break;
            tick();
            pushed++;
        end
        check("fill_pushed", 32'(pushed), 32'd258);
        check("fill_full", 32'(full), 32'h1);
        check("fill_count", 32'(count), 32'd258);
        check("fill_in_ready", 32'(bus.IN_READY), 32'h0);
        check("fill_afull", 32'(afull), 32'h1);
        check("fill_we_blocked", 32'(we), 32'h0);
        check("fill_ovf_before", 32'(ovf), 32'h0);
        check("fill_head", 32'(bus.OUT_DATA), 32'h1000);
        tick();
        check("ovf_set", 32'(ovf), 32'h1);
        check("ovf_count", 32'(count), 32'd258);

        // Drain from full at one word per cycle.
        bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1; n = 0; bad = 0; stall = 0;
        for (int c = 0; c < 400 && n < 258; c++) begin
            if (bus.OUT_VALID) begin
                if (bus.OUT_DATA !== 16'h1000 + 16'(n)) bad++;
                n++;
            end else begin
                stall++;
            end
            tick();
        end
        check("drain_n", 32'(n), 32'd258);
        check("drain_order", 32'(bad), 32'd0);
        check("drain_stalls", 32'(stall), 32'd0);
        check("drain_empty", 32'(empty), 32'h1);
        check("drain_afull", 32'(afull), 32'h0);
        check("ovf_sticky", 32'(ovf), 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ovf", 32'(ovf), 32'h0);
        check("flush_count", 32'(count), 32'd0);

        // Wrap: 1000 words, random consumer back-pressure.
        sent = 0; recv = 0; wp = 8'h00; bad = 0; waddr_bad = 0; wrapped = 0;
        for (int c = 0; c < 6000 && recv < 1000; c++) begin
            bus.OUT_READY = 1'($urandom_range(0, 1));
            bus.IN_VALID  = bus.IN_READY && (sent < 1000);
            bus.IN_DATA   = 16'h2000 + 16'(sent);
            #1;
            did_push = we;
            if (we) begin
                if (waddr !== wp) waddr_bad++;
                if (waddr == 8'h00 && sent > 0) wrapped = 1;
            end
            if (bus.OUT_VALID && bus.OUT_READY) begin
                if (bus.OUT_DATA !== 16'h2000 + 16'(recv)) bad++;
                recv++;
            end
            tick();
            if (did_push) begin
                sent++;
                wp++;
            end
        end
        bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1;
        check("wrap_sent", 32'(sent), 32'd1000);
        check("wrap_recv", 32'(recv), 32'd1000);
        check("wrap_order", 32'(bad), 32'd0);
        check("wrap_waddr", 32'(waddr_bad), 32'd0);
        check("wrap_seen", 32'(wrapped), 32'd1);
        tick(); tick();
        check("wrap_empty", 32'(empty), 32'h1);

        // Throughput: continuous push and pop.
        recv = 0; bad = 0; gaps = 0;
        for (int c = 0; c < 516; c++) begin
            bus.IN_VALID  = (c < 510);
            bus.IN_DATA   = 16'h3000 + 16'(c);
            bus.OUT_READY = 1'b1;
            #1;
            if (bus.OUT_VALID) begin
                if (bus.OUT_DATA !== 16'h3000 + 16'(recv)) bad++;
                recv++;
            end else if (c >= 4 && c < 504) begin
                gaps++;
            end
            tick();
        end
        check("tput_recv", 32'(recv), 32'd510);
        check("tput_order", 32'(bad), 32'd0);
        check("tput_gaps", 32'(gaps), 32'd0);
        check("tput_empty", 32'(empty), 32'h1);

        // FLUSH while a read is in flight.
        bus.IN_VALID = 1'b1; bus.IN_DATA = 16'hDEAD;
        tick();
        bus.IN_VALID = 1'b0;
        #1;
        check("fmr_re", 32'(re), 32'h1);
        tick();
        check("fmr_count_inflight", 32'(count), 32'd1);
        flush = 1'b1;
        #1;
        check("fmr_re_gated", 32'(re), 32'h0);
        tick();
        flush = 1'b0;
        check("fmr_count", 32'(count), 32'd0);
        check("fmr_valid", 32'(bus.OUT_VALID), 32'h0);
        check("fmr_empty", 32'(empty), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fmr_no_stale", 32'(bus.OUT_VALID), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
